// File: rtl/sd_block_reader.sv
// SD card DAT-line block receiver.
// Watches the card clock (generated in the clk domain), samples DAT on each
// sdclk rising edge, assembles bytes, checks per-line CRC16 and the end bit,
// and walks through nblocks blocks. All outputs are registered or decoded
// from registered state, so nothing on sddat reaches an output in the same cycle.
module sd_block_reader #(
    parameter int BUS_WIDTH   = 1,
    parameter int BLOCK_BYTES = 512,
    parameter int DAT_TIMEOUT = 1000000,
    parameter int CRC_CHECK   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sdclk,
    input  logic [3:0]                     sddat,
    input  logic                           start,
    input  logic [15:0]                    nblocks,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic                           crc_err,
    output logic                           timeout,
    output logic                           blk_done,
    output logic [15:0]                    blk_idx,
    output logic                           outreq,
    output logic [$clog2(BLOCK_BYTES)-1:0] outaddr,
    output logic [7:0]                     outbyte
);

    localparam int AW    = $clog2(BLOCK_BYTES);
    localparam int SPB   = 8 / BUS_WIDTH;          // samples per byte
    localparam int LSPB  = $clog2(SPB);
    localparam int NSAMP = BLOCK_BYTES * SPB;      // data samples per block
    localparam int BCW   = $clog2(NSAMP);
    localparam int TW    = $clog2(DAT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, DATA, CRC, ENDBIT, FINISH
    } state_e;

    state_e            state_q, state_d;
    logic              sdclk_q;
    logic [15:0]       nblk_q, nblk_d;
    logic [15:0]       blk_idx_q, blk_idx_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic [7:0]        sh_q, sh_d;
    logic [3:0][15:0]  crc_q, crc_d;
    logic              crc_err_q, crc_err_d;
    logic              tmo_q, tmo_d;
    logic              blk_done_q, blk_done_d;
    logic              outreq_q, outreq_d;
    logic [AW-1:0]     outaddr_q, outaddr_d;
    logic [7:0]        outbyte_q, outbyte_d;

    logic              samp;
    logic [7:0]        sh_nx;
    logic [3:0][15:0]  crc_nx;
    logic              more_blocks;

    // One serial step of CRC16-CCITT (x^16 + x^12 + x^5 + 1).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign samp        = ~sdclk_q & sdclk;
    assign sh_nx       = {sh_q[7-BUS_WIDTH:0], sddat[BUS_WIDTH-1:0]};
    assign more_blocks = ({1'b0, blk_idx_q} + 17'd1) < {1'b0, nblk_q};

    // Per-line CRC advance; unused lines are held at zero. Feeding the
    // received CRC through the same register leaves zero when it matches.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            crc_nx[i] = (i < BUS_WIDTH) ? crc_step(crc_q[i], sddat[i]) : 16'h0000;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state_q;
        nblk_d     = nblk_q;
        blk_idx_d  = blk_idx_q;
        bitcnt_d   = bitcnt_q;
        wait_d     = wait_q;
        sh_d       = sh_q;
        crc_d      = crc_q;
        crc_err_d  = crc_err_q;
        tmo_d      = tmo_q;
        blk_done_d = 1'b0;
        outreq_d   = 1'b0;
        outaddr_d  = '0;
        outbyte_d  = outbyte_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nblk_d    = (nblocks == 16'd0) ? 16'd1 : nblocks;
                    crc_err_d = 1'b0;
                    tmo_d     = 1'b0;
                    blk_idx_d = '0;
                    wait_d    = '0;
                    state_d   = WAIT_START;
                end
            end
            WAIT_START: begin
                if (samp) begin
                    if (~|sddat[BUS_WIDTH-1:0]) begin
                        bitcnt_d = '0;
                        crc_d    = '0;
                        state_d  = DATA;
                    end else if (wait_q >= TW'(DAT_TIMEOUT)) begin
                        tmo_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (samp) begin
                    sh_d     = sh_nx;
                    crc_d    = crc_nx;
                    bitcnt_d = bitcnt_q + BCW'(1);
                    if (&bitcnt_q[LSPB-1:0]) begin
                        outreq_d  = 1'b1;
                        outaddr_d = bitcnt_q[BCW-1:LSPB];
                        outbyte_d = sh_nx;
                    end
                    if (bitcnt_q == BCW'(NSAMP - 1)) begin
                        bitcnt_d = '0;
                        state_d  = CRC;
                    end
                end
            end
            CRC: begin
                if (samp) begin
                    crc_d    = crc_nx;
                    bitcnt_d = bitcnt_q + BCW'(1);
                    if (bitcnt_q == BCW'(15)) begin
                        state_d = ENDBIT;
                        if ((CRC_CHECK != 0) && (|crc_nx)) crc_err_d = 1'b1;
                    end
                end
            end
            ENDBIT: begin
                if (samp) begin
                    if (~&sddat[BUS_WIDTH-1:0]) crc_err_d = 1'b1;
                    blk_done_d = 1'b1;
                    if (more_blocks) begin
                        blk_idx_d = blk_idx_q + 16'd1;
                        wait_d    = '0;
                        state_d   = WAIT_START;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort beats everything else, including a byte completing this cycle.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            outreq_d   = 1'b0;
            outaddr_d  = '0;
            blk_done_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sdclk_q    <= 1'b0;
            nblk_q     <= '0;
            blk_idx_q  <= '0;
            bitcnt_q   <= '0;
            wait_q     <= '0;
            sh_q       <= '0;
            crc_q      <= '0;
            crc_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
            blk_done_q <= 1'b0;
            outreq_q   <= 1'b0;
            outaddr_q  <= '0;
            outbyte_q  <= '0;
        end else begin
            state_q    <= state_d;
            sdclk_q    <= sdclk;
            nblk_q     <= nblk_d;
            blk_idx_q  <= blk_idx_d;
            bitcnt_q   <= bitcnt_d;
            wait_q     <= wait_d;
            sh_q       <= sh_d;
            crc_q      <= crc_d;
            crc_err_q  <= crc_err_d;
            tmo_q      <= tmo_d;
            blk_done_q <= blk_done_d;
            outreq_q   <= outreq_d;
            outaddr_q  <= outaddr_d;
            outbyte_q  <= outbyte_d;
        end
    end

    assign busy     = (state_q != IDLE) && (state_q != FINISH);
    assign done     = (state_q == FINISH);
    assign crc_err  = crc_err_q;
    assign timeout  = tmo_q;
    assign blk_done = blk_done_q;
    assign blk_idx  = blk_idx_q;
    assign outreq   = outreq_q;
    assign outaddr  = outaddr_q;
    assign outbyte  = outbyte_q;

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BUS_WIDTH, 1: active DAT lines; legal values 1 or 4.
- BLOCK_BYTES, 512: bytes per block; power of two, 16..2048.
- DAT_TIMEOUT, 1000000: maximum sdclk rising edges to wait for a start bit.
- CRC_CHECK, 1: 1 = verify CRC16; 0 = skip the compare but still consume the CRC bits.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst_n, in, 1: asynchronous active-low reset.
- sdclk, in, 1: card clock, generated in the clk domain.
- sddat, in, 4: card DAT lines; only [BUS_WIDTH-1:0] are used.
- start, in, 1: one-cycle transfer request.
- nblocks, in, 16: number of blocks to receive; 0 is treated as 1.
- abort, in, 1: cancel the transfer.
- busy, out, 1: transfer in progress.
- done, out, 1: one-cycle completion pulse.
- crc_err, out, 1: CRC status of the last transfer.
- timeout, out, 1: timeout status of the last transfer.
- blk_done, out, 1: one-cycle pulse per good or bad block.
- blk_idx, out, 16: index of the block currently being received.
- outreq, out, 1: byte strobe.
- outaddr, out, log2(BLOCK_BYTES): byte offset within the block.
- outbyte, out, 8: received byte.

REQ-003 The clock SHALL be clk; reset SHALL be rst_n, asynchronous and active-low. No other clock exists.

Function
REQ-004 Edge detection: sdclk SHALL be registered every clk cycle. A sample event SHALL occur in any cycle where the registered value is 0 and sdclk is 1. sddat SHALL be sampled only on sample events.

REQ-005 States SHALL be IDLE, WAIT_START, DATA, CRC, ENDBIT, FINISH.

REQ-006 IDLE: start=1 SHALL latch max(nblocks,1), clear crc_err/timeout/blk_idx, set busy=1, and enter WAIT_START on the next cycle. start while busy=1 SHALL be ignored.

REQ-007 WAIT_START: a start bit is all used lines = 0 at a sample event.
- Start bit seen: clear the bit counter and CRC registers, enter DATA.
- Otherwise increment the wait counter. When it exceeds DAT_TIMEOUT, set timeout=1 and enter FINISH.
- The wait counter SHALL reset on each WAIT_START entry.

REQ-008 DATA, BUS_WIDTH=1: sddat[0] is shifted MSB first. The byte completes on every 8th sample.

REQ-009 DATA, BUS_WIDTH=4: the first sample is byte[7:4] and the second is byte[3:0]. The byte completes on every 2nd sample.

REQ-010 On byte completion, outreq SHALL be 1 for exactly one clk cycle, with outaddr = byte index (0..BLOCK_BYTES-1) and outbyte valid in that same cycle. outreq SHALL be 0 and outaddr 0 in all other cycles.

REQ-011 After byte BLOCK_BYTES-1 completes, the block SHALL enter CRC.

REQ-012 CRC computation: each used line SHALL have an independent CRC16-CCITT (x^16+x^12+x^5+1), initialised to 0 and updated with every data bit on that line.

REQ-013 CRC state: SHALL receive 16 bits per used line, MSB first, and then enter ENDBIT. If CRC_CHECK=1 and any line mismatches, crc_err SHALL be set. crc_err is sticky until the next start.

REQ-014 ENDBIT: the next sample event is consumed.
- If any used line is 0, crc_err SHALL be set.
- blk_done SHALL pulse for one cycle.
- If blocks remain, blk_idx SHALL increment and the state SHALL return to WAIT_START.
- Otherwise the state SHALL enter FINISH.
- A CRC error SHALL NOT stop the remaining blocks.

REQ-015 FINISH: in one cycle, done=1 and busy=0, then the state SHALL return to IDLE. crc_err and timeout SHALL be valid in the done cycle and held until the next accepted start.

REQ-016 abort=1 in any non-IDLE state SHALL return to IDLE on the next clock edge, with busy=0 and no done or blk_done pulse. A pending outreq SHALL be dropped. abort in IDLE SHALL have no effect.

REQ-017 Simultaneous events:
- abort and a byte completion in the same cycle: abort wins.
- start and abort in the same IDLE cycle: start is taken.

REQ-018 No combinational path SHALL exist from sddat to any output.

Reset
REQ-019 While rst_n=0, all of the following SHALL be 0 and the state SHALL be IDLE: busy, done, crc_err, timeout, blk_done, blk_idx, outreq, outaddr, outbyte, the registered sdclk, all counters and all CRC registers.

REQ-020 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse. After release, the block SHALL accept a new start.

Verification
REQ-021 BUS_WIDTH=1, BLOCK_BYTES=512, nblocks=1, card sends bytes 0x00..0xFF twice plus a correct CRC -> 512 outreq pulses with outaddr 0..511 and outbyte = addr[7:0], then one blk_done, then done with crc_err=0 and timeout=0.

REQ-022 BUS_WIDTH=4, nblocks=3, three correct blocks -> blk_idx takes the values 0,1,2, 3 blk_done pulses and 1536 outreq pulses, then done with crc_err=0.

REQ-023 BUS_WIDTH=4, line 2 CRC bit 5 flipped in block 1 of 2 -> both blocks are streamed, and done has crc_err=1.

REQ-024 DAT_TIMEOUT=200, sddat held at 0xF -> done after the 201st sample edge with timeout=1 and zero outreq pulses.

REQ-025 abort asserted after outaddr 100 -> busy=0 on the next cycle, no further outreq, no done. A subsequent start receives a full correct block.

REQ-026 rst_n pulsed low mid-block -> every output is 0 while rst_n=0, and the next start behaves as in REQ-021.
